sar_search: RTL and testbench

Successive-approximation searcher: the initiator that drives a probe value into the registered magnitude comparator (`top`-style, 2-bit result code) and reads the code back to locate an unknown target by binary search. It supports any comparator pipeline depth via `CMP_LAT` and reports the found value, or a not-found/error status, with a one-cycle `done` pulse.

---
 rtl/sar_search.sv | 135 +++++++++++++
 tb/tb_sar_search.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation searcher: drives a probe into a magnitude comparator
// and binary-searches for the target, reporting found/not-found/error with a done pulse.
module sar_search #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmp_code,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam int CW = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, lo_n, hi, hi_n, probe_n, result_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             found_n, err_n;
  logic [WIDTH:0]   lo_x, hi_x, sum_x;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= MAXV;
      probe  <= '0;
      cnt    <= '0;
      found  <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      probe  <= probe_n;
      cnt    <= cnt_n;
      found  <= found_n;
      result <= result_n;
      err    <= err_n;
    end
  end

  // Bounds arithmetic is one bit wider so lo+hi and the +/-1 steps never wrap.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    probe_n  = probe;
    cnt_n    = cnt;
    found_n  = found;
    result_n = result;
    err_n    = err;
    lo_x     = {1'b0, lo};
    hi_x     = {1'b0, hi};
    sum_x    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = MAXV;
          sum_x    = {1'b0, MAXV};
          probe_n  = sum_x[WIDTH:1];
          found_n  = 1'b0;
          result_n = '0;
          err_n    = 1'b0;
          cnt_n    = CW'(CMP_LAT);
          state_n  = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = DONE;
          case (cmp_code)
            2'b00: begin
              found_n  = 1'b1;
              result_n = probe;
            end
            2'b10: begin
              if (probe != MAXV) begin
                lo_x = {1'b0, probe} + (WIDTH+1)'(1);
                lo_n = lo_x[WIDTH-1:0];
                if (lo_x <= hi_x) begin
                  sum_x   = lo_x + hi_x;
                  probe_n = sum_x[WIDTH:1];
                  cnt_n   = CW'(CMP_LAT);
                  state_n = WAIT;
                end
              end
            end
            2'b01: begin
              if (probe != '0) begin
                hi_x = {1'b0, probe} - (WIDTH+1)'(1);
                hi_n = hi_x[WIDTH-1:0];
                if (lo_x <= hi_x) begin
                  sum_x   = lo_x + hi_x;
                  probe_n = sum_x[WIDTH:1];
                  cnt_n   = CW'(CMP_LAT);
                  state_n = WAIT;
                end
              end
            end
            default: begin
              err_n   = 1'b1;
              found_n = 1'b0;
            end
          endcase
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == WAIT);
    done      = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: vector table of full searches on CMP_LAT=1 and CMP_LAT=3
// instances, plus hand sequences for reset abort, start-while-busy and held start.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [1:0] cmp1, cmp3;
  logic [3:0] probe1, probe3, result1, result3;
  logic       busy1, busy3, done1, done3, found1, found3, err1, err3;
  logic [1:0] st1, st3;

  logic [3:0] target = 4'd0;
  int         mode = 0;
  bit         use3 = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [3:0] m_probe, m_result;
  logic       m_busy, m_done, m_found, m_err;

  always #5 clk = ~clk;

  sar_search #(.WIDTH(4), .CMP_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cmp_code(cmp1),
    .probe(probe1), .busy(busy1), .done(done1), .found(found1),
    .result(result1), .err(err1), .state_dbg(st1)
  );

  sar_search #(.WIDTH(4), .CMP_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .cmp_code(cmp3),
    .probe(probe3), .busy(busy3), .done(done3), .found(found3),
    .result(result3), .err(err3), .state_dbg(st3)
  );

  // Comparator model: mode 1 always answers "target<probe", mode 2 reports invalid at probe 11.
  function automatic logic [1:0] cmp_fn(input logic [3:0] t, input logic [3:0] p, input int m);
    if (m == 1) return 2'b01;
    if (m == 2 && p == 4'd11) return 2'b11;
    if (t > p) return 2'b10;
    if (t < p) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    cmp1 = cmp_fn(target, probe1, mode);
    cmp3 = cmp_fn(target, probe3, mode);
    m_probe  = use3 ? probe3  : probe1;
    m_result = use3 ? result3 : result1;
    m_busy   = use3 ? busy3   : busy1;
    m_done   = use3 ? done3   : done1;
    m_found  = use3 ? found3  : found1;
    m_err    = use3 ? err3    : err1;
  end

  typedef struct {
    logic [3:0]      tgt;
    int              mode;
    int              lat;
    int              nprobe;
    logic [4:0][3:0] probes;
    logic            f;
    logic [3:0]      r;
    logic            e;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] tgt, input int md, input int lat, input int np,
                              input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2,
                              input logic [3:0] p3, input logic [3:0] p4,
                              input logic f, input logic [3:0] r, input logic e);
    vec_t v;
    v.tgt = tgt; v.mode = md; v.lat = lat; v.nprobe = np;
    v.probes[0] = p0; v.probes[1] = p1; v.probes[2] = p2; v.probes[3] = p3; v.probes[4] = p4;
    v.f = f; v.r = r; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Full search: E0 is the start-accept edge; samples taken 1 time unit after each edge.
  // Probe k is shown from edge (k-1)*lat; done is visible after the final sampling edge last=k*lat.
  task automatic run_vec(input int id, input vec_t v, input bit extra);
    int last;
    target = v.tgt;
    mode   = v.mode;
    use3   = (v.lat == 3);
    @(negedge clk);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    chk($sformatf("v%0d busy@E0", id), m_busy, 1);
    chk($sformatf("v%0d probe@E0", id), m_probe, v.probes[0]);
    last = v.nprobe * v.lat;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      if (n < last) begin
        chk($sformatf("v%0d probe@E%0d", id, n), m_probe, v.probes[n / v.lat]);
        chk($sformatf("v%0d busy@E%0d", id, n), m_busy, 1);
        chk($sformatf("v%0d done@E%0d", id, n), m_done, 0);
      end else begin
        chk($sformatf("v%0d done@end", id), m_done, 1);
        chk($sformatf("v%0d busy@end", id), m_busy, 0);
        chk($sformatf("v%0d probe@end", id), m_probe, v.probes[v.nprobe - 1]);
        chk($sformatf("v%0d found", id), m_found, v.f);
        chk($sformatf("v%0d result", id), m_result, v.r);
        chk($sformatf("v%0d err", id), m_err, v.e);
      end
      if (extra && n == 1) start1 = 1'b1;
      if (extra && n == 2) start1 = 1'b0;
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse_end", id), m_done, 0);
    chk($sformatf("v%0d result_held", id), m_result, v.r);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(4'd10, 0, 1, 4, 4'd7, 4'd11, 4'd9,  4'd10, 4'd0,  1'b1, 4'd10, 1'b0);
    vecs[1] = mk(4'd7,  0, 1, 1, 4'd7, 4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 4'd7,  1'b0);
    vecs[2] = mk(4'd0,  0, 1, 4, 4'd7, 4'd3,  4'd1,  4'd0,  4'd0,  1'b1, 4'd0,  1'b0);
    vecs[3] = mk(4'd15, 0, 1, 5, 4'd7, 4'd11, 4'd13, 4'd14, 4'd15, 1'b1, 4'd15, 1'b0);
    vecs[4] = mk(4'd5,  0, 1, 3, 4'd7, 4'd3,  4'd5,  4'd0,  4'd0,  1'b1, 4'd5,  1'b0);
    vecs[5] = mk(4'd5,  1, 1, 4, 4'd7, 4'd3,  4'd1,  4'd0,  4'd0,  1'b0, 4'd0,  1'b0);
    vecs[6] = mk(4'd10, 2, 1, 2, 4'd7, 4'd11, 4'd0,  4'd0,  4'd0,  1'b0, 4'd0,  1'b1);
    vecs[7] = mk(4'd10, 0, 1, 4, 4'd7, 4'd11, 4'd9,  4'd10, 4'd0,  1'b1, 4'd10, 1'b0);
    vecs[8] = mk(4'd10, 0, 3, 4, 4'd7, 4'd11, 4'd9,  4'd10, 4'd0,  1'b1, 4'd10, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst probe", probe1, 0);
    chk("rst busy", busy1, 0);
    chk("rst done", done1, 0);
    chk("rst found", found1, 0);
    chk("rst result", result1, 0);
    chk("rst err", err1, 0);
    chk("rst state", st1, 0);
    chk("rst probe3", probe3, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i], 1'b0);

    // start pulsed while busy must not disturb the search
    run_vec(20, vecs[0], 1'b1);

    // Reset asserted mid-search, between edges, right after probe 11 appears
    target = 4'd10; mode = 0; use3 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1;
    chk("abort probe11", probe1, 11);
    #3 reset = 1'b0;
    #1;
    chk("abort probe", probe1, 0);
    chk("abort busy", busy1, 0);
    chk("abort done", done1, 0);
    chk("abort found", found1, 0);
    chk("abort result", result1, 0);
    chk("abort err", err1, 0);
    chk("abort state", st1, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort no_done c%0d", k), done1, 0);
    end
    @(negedge clk); reset = 1'b1;
    run_vec(21, vecs[0], 1'b0);

    // start held across DONE: next search begins on the first edge back in IDLE
    target = 4'd7; mode = 0; use3 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    chk("hold busy@E0", busy1, 1);
    @(posedge clk); #1;
    chk("hold done@E1", done1, 1);
    chk("hold result@E1", result1, 7);
    @(posedge clk); #1;
    chk("hold done@E2", done1, 0);
    chk("hold busy@E2", busy1, 0);
    chk("hold state@E2", st1, 0);
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("hold busy@E3", busy1, 1);
    chk("hold probe@E3", probe1, 7);
    chk("hold found_cleared@E3", found1, 0);
    @(posedge clk); #1;
    chk("hold done@E4", done1, 1);
    chk("hold found@E4", found1, 1);
    @(posedge clk); #1;
    chk("hold done@E5", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
